// File: rtl/adder_mp_seq_if.sv
// Operand/result handshake bundle for adder_mp_seq; master drives operands, slave is the sequencer.
// Sub_i exists only when ADDER_MP_SUB_EN is defined.
interface adder_mp_seq_if #(
  parameter int BW_DATA = 32,
  parameter int NWORD   = 4
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [BW_DATA*NWORD-1:0] A_i;
  logic [BW_DATA*NWORD-1:0] B_i;
  logic                     Cin;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [BW_DATA*NWORD-1:0] S_o;
  logic                     Cout_o;
`ifdef ADDER_MP_SUB_EN
  logic                     Sub_i;

  modport master (
    output in_valid_i, A_i, B_i, Cin, Sub_i, out_ready_i,
    input  in_ready_o, out_valid_o, S_o, Cout_o
  );
  modport slave (
    input  in_valid_i, A_i, B_i, Cin, Sub_i, out_ready_i,
    output in_ready_o, out_valid_o, S_o, Cout_o
  );
`else
  modport master (
    output in_valid_i, A_i, B_i, Cin, out_ready_i,
    input  in_ready_o, out_valid_o, S_o, Cout_o
  );
  modport slave (
    input  in_valid_i, A_i, B_i, Cin, out_ready_i,
    output in_ready_o, out_valid_o, S_o, Cout_o
  );
`endif
endinterface

// File: rtl/adder_mp_seq.sv
// Multi-precision adder: one word per cycle LSW first, result NWORD cycles after acceptance, held until out_ready_i.
// No input accepted while busy or holding a result; ADDER_MP_SUB_EN adds a Sub_i port for A-B.
module adder_cla #(
  parameter int BW = 32
) (
  input  logic [BW-1:0] A_i,
  input  logic [BW-1:0] B_i,
  input  logic          Cin,
  output logic [BW-1:0] S_o,
  output logic          Cout_o
);
  localparam int N  = BW + 1;
  localparam int LV = $clog2(N);

  logic [N-1:0] g, p, gn, pn;

  // Kogge-Stone prefix over {operands, Cin}; bit 0 carries Cin as a generate.
  always_comb begin
    g  = {A_i & B_i, Cin};
    p  = {A_i ^ B_i, 1'b0};
    gn = g;
    pn = p;
    for (int l = 0; l < LV; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < N; i++) begin
        gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
        pn[i] = p[i] & p[i-(1<<l)];
      end
      g = gn;
      p = pn;
    end
  end

  assign S_o    = (A_i ^ B_i) ^ g[BW-1:0];
  assign Cout_o = g[BW];
endmodule

module adder_mp_seq #(
  parameter int BW_DATA = 32,
  parameter int NWORD   = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  adder_mp_seq_if.slave     bus
);
  localparam int W  = BW_DATA * NWORD;
  localparam int IW = $clog2(NWORD);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [W-1:0]       a_q, b_q, s_q;
  logic               carry_q, cout_q, out_valid_q;
  logic [IW-1:0]      idx_q;
  logic [BW_DATA-1:0] a_word, b_word, sum_word;
  logic               carry_out;
  logic               last_word;
`ifdef ADDER_MP_SUB_EN
  logic               sub_q;
`endif

  assign a_word = a_q[idx_q*BW_DATA +: BW_DATA];
`ifdef ADDER_MP_SUB_EN
  assign b_word = b_q[idx_q*BW_DATA +: BW_DATA] ^ {BW_DATA{sub_q}};
`else
  assign b_word = b_q[idx_q*BW_DATA +: BW_DATA];
`endif
  assign last_word = (idx_q == IW'(NWORD - 1));

  adder_cla #(.BW(BW_DATA)) u_cla (
    .A_i    (a_word),
    .B_i    (b_word),
    .Cin    (carry_q),
    .S_o    (sum_word),
    .Cout_o (carry_out)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
`ifdef ADDER_MP_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            a_q   <= bus.A_i;
            b_q   <= bus.B_i;
            idx_q <= '0;
            state <= CALC;
`ifdef ADDER_MP_SUB_EN
            sub_q   <= bus.Sub_i;
            // Two's complement subtract: inverted B plus a forced carry of one.
            carry_q <= bus.Sub_i | bus.Cin;
`else
            carry_q <= bus.Cin;
`endif
          end
        end
        CALC: begin
          s_q[idx_q*BW_DATA +: BW_DATA] <= sum_word;
          carry_q <= carry_out;
          idx_q   <= idx_q + 1'b1;
          if (last_word) begin
            cout_q      <= carry_out;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = out_valid_q;
  assign bus.S_o         = s_q;
  assign bus.Cout_o      = cout_q;
endmodule

// File: tb/tb_adder_mp_seq.sv
// Directed bench for adder_mp_seq with a result scoreboard; also covers Sub_i when ADDER_MP_SUB_EN is defined.
module tb_adder_mp_seq;
  localparam int BW_DATA = 32;
  localparam int NWORD   = 4;
  localparam int W       = BW_DATA * NWORD;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  logic [W:0] sb[$];
  logic [W:0] exp_r;

  adder_mp_seq_if #(.BW_DATA(BW_DATA), .NWORD(NWORD)) bus ();

  adder_mp_seq #(.BW_DATA(BW_DATA), .NWORD(NWORD)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one operand set at a negedge; push the reference result once accepted.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    logic [W:0] r;
    int n;
    bus.A_i = a;
    bus.B_i = b;
    bus.Cin = cin;
`ifdef ADDER_MP_SUB_EN
    bus.Sub_i = sub;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`else
    r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    if (sub) r = 'x;
`endif
    bus.in_valid_i = 1'b1;
    n = 0;
    while (bus.in_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_at_accept", (W+1)'(bus.in_ready_o), (W+1)'(1));
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    sb.push_back(r);
  endtask

  // Count edges until out_valid_o, then compare against the scoreboard head.
  task automatic wait_result(input string tag, output logic [W:0] expv);
    int n;
    n = 0;
    while (bus.out_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, (W+1)'(n), (W+1)'(NWORD));
    if (sb.size() > 0) expv = sb.pop_front();
    else expv = 'x;
    chk({tag, "_sum"},  (W+1)'(bus.S_o),    (W+1)'(expv[W-1:0]));
    chk({tag, "_cout"}, (W+1)'(bus.Cout_o), (W+1)'(expv[W]));
  endtask

  task automatic release_result(input string tag);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, (W+1)'(bus.out_valid_o), '0);
    chk({tag, "_ready_back"}, (W+1)'(bus.in_ready_o), (W+1)'(1));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},  (W+1)'(bus.in_ready_o),  (W+1)'(1));
    chk({tag, "_out_valid"}, (W+1)'(bus.out_valid_o), '0);
    chk({tag, "_sum"},       (W+1)'(bus.S_o),         '0);
    chk({tag, "_cout"},      (W+1)'(bus.Cout_o),      '0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int vhits;
    rstn = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.A_i = '0;
    bus.B_i = '0;
    bus.Cin = 1'b0;
`ifdef ADDER_MP_SUB_EN
    bus.Sub_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    // All ones plus carry-in wraps to zero with a carry out.
    start_op({W{1'b1}}, '0, 1'b1, 1'b0);
    wait_result("allones", exp_r);
    release_result("allones");

    // Carry crossing the first word boundary.
    start_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1'b0);
    wait_result("wordcarry", exp_r);
    chk("wordcarry_literal", (W+1)'(bus.S_o), (W+1)'(128'h0000_0000_0000_0000_0000_0001_0000_0000));
    release_result("wordcarry");

    // Carry rippling through every word except the top one.
    start_op(128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0);
    wait_result("ripple", exp_r);
    release_result("ripple");

    // Backpressure: result held, input ignored, no queued operation afterwards.
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    start_op(ra, rb, 1'b1, 1'b0);
    wait_result("bp", exp_r);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.A_i = '1;
        bus.B_i = '1;
        bus.in_valid_i = 1'b1;
      end
      if (i == 2) bus.in_valid_i = 1'b0;
      @(negedge clk);
      chk("bp_hold_valid", (W+1)'(bus.out_valid_o), (W+1)'(1));
      chk("bp_hold_sum",   (W+1)'(bus.S_o),         (W+1)'(exp_r[W-1:0]));
      chk("bp_hold_cout",  (W+1)'(bus.Cout_o),      (W+1)'(exp_r[W]));
      chk("bp_in_ready",   (W+1)'(bus.in_ready_o),  '0);
    end
    release_result("bp");
    vhits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b0) vhits++;
    end
    chk("bp_no_queued_op", (W+1)'(vhits), '0);
    chk("bp_sum_kept", (W+1)'(bus.S_o), (W+1)'(exp_r[W-1:0]));

    // Reset while the third word is being processed.
    start_op({W{1'b1}}, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_state("midreset");
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    vhits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b0) vhits++;
    end
    chk("midreset_no_valid", (W+1)'(vhits), '0);
    start_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 1'b1, 1'b0);
    wait_result("after_reset", exp_r);
    release_result("after_reset");

    // A few random additions back to back.
    for (int k = 0; k < 3; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      start_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      wait_result("random", exp_r);
      release_result("random");
    end

`ifdef ADDER_MP_SUB_EN
    start_op(128'd5, 128'd7, 1'b0, 1'b1);
    wait_result("sub_neg", exp_r);
    chk("sub_neg_literal", (W+1)'(bus.S_o), (W+1)'({{(W-4){1'b1}}, 4'hE}));
    chk("sub_neg_borrow", (W+1)'(bus.Cout_o), '0);
    release_result("sub_neg");
    start_op(128'd7, 128'd5, 1'b0, 1'b1);
    wait_result("sub_pos", exp_r);
    chk("sub_pos_literal", (W+1)'(bus.S_o), (W+1)'(2));
    chk("sub_pos_noborrow", (W+1)'(bus.Cout_o), (W+1)'(1));
    release_result("sub_pos");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
